// File: rtl/up_down_mod_cnt.sv
// Modulo up/down counter with load, wrap/saturate limits, out-of-range load flag
// and one-cycle compare/terminal event pulses for timekeeping ticks.
module up_down_mod_cnt #(
  parameter int                       WIDTH    = 17,
  parameter int                       MAX_VAL  = 86399,
  parameter bit                       WRAP     = 1'b1,
  parameter int                       NUM_CMP  = 3,
  parameter logic [NUM_CMP*WIDTH-1:0] CMP_VALS = {17'd86399, 17'd3600, 17'd256}
) (
  input  logic               cnt_clk,
  input  logic               cnt_rst_n,
  input  logic               en,
  input  logic               up_pulse,
  input  logic               down_pulse,
  input  logic               load_pulse,
  input  logic [WIDTH-1:0]   load_value,
  output logic [WIDTH-1:0]   count_out,
  output logic               wrap_pulse,
  output logic               at_limit,
  output logic               load_err,
  output logic [NUM_CMP-1:0] cmp_pulse,
  output logic               out_pulse
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  if (longint'(MAX_VAL) >= (longint'(1) << WIDTH) || MAX_VAL < 0) begin : g_bad_max
    $error("up_down_mod_cnt: MAX_VAL does not fit in WIDTH bits");
  end
  if (NUM_CMP < 1 || NUM_CMP > 8) begin : g_bad_num_cmp
    $error("up_down_mod_cnt: NUM_CMP must be 1..8");
  end
  for (genvar g = 0; g < NUM_CMP; g++) begin : g_cmp_chk
    if (CMP_VALS[g*WIDTH +: WIDTH] > MAX_W) begin : g_bad_cmp
      $error("up_down_mod_cnt: CMP_VALS slice exceeds MAX_VAL");
    end
  end

  logic [WIDTH-1:0]   r_cnt;
  logic               r_wrap;
  logic               r_lerr;
  logic [NUM_CMP-1:0] r_cmp;
  logic               r_out;

  logic [WIDTH-1:0]   w_next_cnt;
  logic               w_update;
  logic               w_wrap;
  logic               w_lerr;
  logic [NUM_CMP-1:0] w_cmp;

  // Load beats stepping; up and down together cancel out with no event.
  always_comb begin
    w_next_cnt = r_cnt;
    w_update   = 1'b0;
    w_wrap     = 1'b0;
    w_lerr     = 1'b0;
    if (load_pulse) begin
      w_update = 1'b1;
      if (load_value > MAX_W) begin
        w_next_cnt = MAX_W;
        w_lerr     = 1'b1;
      end else begin
        w_next_cnt = load_value;
      end
    end else if (en && up_pulse && !down_pulse) begin
      if (r_cnt < MAX_W) begin
        w_next_cnt = r_cnt + WIDTH'(1);
        w_update   = 1'b1;
      end else if (WRAP) begin
        w_next_cnt = '0;
        w_wrap     = 1'b1;
        w_update   = 1'b1;
      end
    end else if (en && down_pulse && !up_pulse) begin
      if (r_cnt != '0) begin
        w_next_cnt = r_cnt - WIDTH'(1);
        w_update   = 1'b1;
      end else if (WRAP) begin
        w_next_cnt = MAX_W;
        w_wrap     = 1'b1;
        w_update   = 1'b1;
      end
    end
  end

  // Compare pulses fire only on an update landing on the value, never on hold.
  always_comb begin
    w_cmp = '0;
    for (int i = 0; i < NUM_CMP; i++) begin
      w_cmp[i] = w_update && (w_next_cnt == CMP_VALS[i*WIDTH +: WIDTH]);
    end
  end

  always_ff @(posedge cnt_clk or negedge cnt_rst_n) begin
    if (!cnt_rst_n) begin
      r_cnt  <= '0;
      r_wrap <= 1'b0;
      r_lerr <= 1'b0;
      r_cmp  <= '0;
      r_out  <= 1'b0;
    end else begin
      r_cnt  <= w_next_cnt;
      r_wrap <= w_wrap;
      r_lerr <= w_lerr;
      r_cmp  <= w_cmp;
      r_out  <= |w_cmp;
    end
  end

  assign count_out  = r_cnt;
  assign wrap_pulse = r_wrap;
  assign load_err   = r_lerr;
  assign cmp_pulse  = r_cmp;
  assign out_pulse  = r_out;
  assign at_limit   = (r_cnt == '0) || (r_cnt == MAX_W);

endmodule

// File: tb/tb_up_down_mod_cnt.sv
// Bench for up_down_mod_cnt: a wrapping and a saturating instance share stimulus
// and are checked every cycle against an arithmetic reference model.
module tb_up_down_mod_cnt;
  localparam int W    = 17;
  localparam int MAXV = 86399;
  localparam int NC   = 3;

  int cmp_tab[NC] = '{256, 3600, 86399};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0, up = 1'b0, dn = 1'b0, ld = 1'b0;
  logic [W-1:0]  lv = '0;

  logic [W-1:0]  c_w, c_s;
  logic          wp_w, wp_s, al_w, al_s, le_w, le_s, op_w, op_s;
  logic [NC-1:0] cp_w, cp_s;

  int n_tests = 0;
  int n_fail  = 0;
  int m_cnt[2];

  always #5 clk = ~clk;

  up_down_mod_cnt #(.WRAP(1'b1)) u_wrap (
    .cnt_clk(clk), .cnt_rst_n(rst_n), .en(en), .up_pulse(up), .down_pulse(dn),
    .load_pulse(ld), .load_value(lv), .count_out(c_w), .wrap_pulse(wp_w),
    .at_limit(al_w), .load_err(le_w), .cmp_pulse(cp_w), .out_pulse(op_w)
  );

  up_down_mod_cnt #(.WRAP(1'b0)) u_sat (
    .cnt_clk(clk), .cnt_rst_n(rst_n), .en(en), .up_pulse(up), .down_pulse(dn),
    .load_pulse(ld), .load_value(lv), .count_out(c_s), .wrap_pulse(wp_s),
    .at_limit(al_s), .load_err(le_s), .cmp_pulse(cp_s), .out_pulse(op_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance the model of instance k by one edge and compare all its outputs.
  task automatic model_check(input int k, input string nm, input logic [31:0] o_cnt,
                             input logic [31:0] o_wrap, input logic [31:0] o_lim,
                             input logic [31:0] o_lerr, input logic [31:0] o_cmp,
                             input logic [31:0] o_out);
    int old, m, wrp, lerr, upd, ecmp, ilv;
    old  = m_cnt[k];
    m    = old;
    wrp  = 0;
    lerr = 0;
    upd  = 0;
    ilv  = int'(lv);
    if (ld) begin
      upd = 1;
      if (ilv > MAXV) begin m = MAXV; lerr = 1; end
      else m = ilv;
    end else if (en && (up != dn)) begin
      if (up) begin
        if (k == 0) begin m = (old + 1) % (MAXV + 1); wrp = (old == MAXV); end
        else m = (old < MAXV) ? old + 1 : old;
      end else begin
        if (k == 0) begin m = (old + MAXV) % (MAXV + 1); wrp = (old == 0); end
        else m = (old > 0) ? old - 1 : old;
      end
      upd = (m != old) || (wrp != 0);
    end
    ecmp = 0;
    for (int i = 0; i < NC; i++)
      if (upd != 0 && m == cmp_tab[i]) ecmp = ecmp | (1 << i);
    m_cnt[k] = m;
    check({nm, "_count"}, o_cnt, m);
    check({nm, "_wrap"}, o_wrap, wrp);
    check({nm, "_at_limit"}, o_lim, (m == 0 || m == MAXV) ? 1 : 0);
    check({nm, "_load_err"}, o_lerr, lerr);
    check({nm, "_cmp"}, o_cmp, ecmp);
    check({nm, "_out"}, o_out, (ecmp != 0) ? 1 : 0);
  endtask

  task automatic cycle(input logic i_ld, input int i_lv, input logic i_en,
                       input logic i_up, input logic i_dn);
    ld = i_ld;
    lv = W'(i_lv);
    en = i_en;
    up = i_up;
    dn = i_dn;
    @(posedge clk);
    #1;
    model_check(0, "wrap", 32'(c_w), 32'(wp_w), 32'(al_w), 32'(le_w), 32'(cp_w), 32'(op_w));
    model_check(1, "sat",  32'(c_s), 32'(wp_s), 32'(al_s), 32'(le_s), 32'(cp_s), 32'(op_s));
  endtask

  task automatic check_reset_state();
    check("rst_count_w", 32'(c_w), 0);
    check("rst_count_s", 32'(c_s), 0);
    check("rst_at_limit", 32'({al_w, al_s}), 3);
    check("rst_pulses", 32'({wp_w, le_w, cp_w, op_w, wp_s, le_s, cp_s, op_s}), 0);
  endtask

  initial begin
    int lvr;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    #2;
    check_reset_state();
    #10 rst_n = 1'b1;
    cycle(0, 0, 0, 0, 0);

    // reset mid-count
    cycle(1, 500, 1, 0, 0);
    check("p1_preload", 32'(c_w), 500);
    #3 rst_n = 1'b0;
    #1;
    check_reset_state();
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    #2 rst_n = 1'b1;
    cycle(0, 0, 1, 1, 0);
    check("p1_first_up", 32'(c_w), 1);

    // wrap up then down
    cycle(1, MAXV, 1, 0, 0);
    cycle(0, 0, 1, 1, 0);
    check("p2_up_cnt", 32'(c_w), 0);
    check("p2_up_wrap", 32'(wp_w), 1);
    check("p2_up_cmp", 32'(cp_w), 0);
    cycle(0, 0, 1, 0, 1);
    check("p2_dn_cnt", 32'(c_w), MAXV);
    check("p2_dn_wrap", 32'(wp_w), 1);
    check("p2_dn_cmp", 32'(cp_w), 4);
    check("p2_dn_out", 32'(op_w), 1);
    cycle(0, 0, 1, 0, 0);
    check("p2_wrap_cleared", 32'(wp_w), 0);

    // saturate at zero
    cycle(1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 0, 1);
      check("p3_sat_cnt", 32'(c_s), 0);
      check("p3_sat_wrap", 32'(wp_s), 0);
      check("p3_sat_lim", 32'(al_s), 1);
    end

    // compare edge behaviour
    cycle(1, 255, 1, 0, 0);
    cycle(0, 0, 1, 1, 0);
    check("p4_cnt", 32'(c_w), 256);
    check("p4_cmp", 32'(cp_w), 1);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 1, 0, 0);
      check("p4_hold_cmp", 32'(cp_w), 0);
    end
    cycle(1, 256, 1, 0, 0);
    check("p4_reload_cmp", 32'(cp_w), 1);

    // priority and simultaneity
    cycle(1, 3600, 1, 1, 0);
    check("p5_ld_cnt", 32'(c_w), 3600);
    check("p5_ld_cmp", 32'(cp_w), 2);
    cycle(0, 0, 1, 1, 1);
    check("p5_updn_cnt", 32'(c_w), 3600);
    check("p5_updn_pulses", 32'({wp_w, cp_w, op_w}), 0);
    cycle(0, 0, 0, 1, 0);
    check("p5_en0_cnt", 32'(c_w), 3600);

    // out-of-range load
    cycle(1, 100000, 1, 0, 0);
    check("p6_cnt", 32'(c_w), MAXV);
    check("p6_lerr", 32'(le_w), 1);
    check("p6_cmp", 32'(cp_w), 4);
    check("p6_wrap", 32'(wp_w), 0);
    cycle(0, 0, 1, 0, 0);
    check("p6_lerr_cleared", 32'(le_w), 0);

    // randomized traffic biased toward limits and compare values
    for (int n = 0; n < 3000; n++) begin
      case ($urandom % 6)
        0: lvr = 0;
        1: lvr = MAXV;
        2: lvr = MAXV + 1 + int'($urandom % (131072 - MAXV - 1));
        3: lvr = cmp_tab[$urandom % 3] - int'($urandom % 2);
        default: lvr = int'($urandom % (MAXV + 1));
      endcase
      cycle(($urandom % 12) == 0, lvr, ($urandom % 4) != 0,
            1'($urandom % 2), 1'($urandom % 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
